// File: rtl/uart_tx_buf_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit buffer and the UART receiver.
//   - tx_state_t : transmitter FSM states (IDLE, LOAD, SHIFT)
//   - FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
//   - DATA_BITS  : payload bits per frame
//   - frame_of() : builds the 10-bit shift-register image of one byte
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } tx_state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  // Stop bit in the MSB, start bit in the LSB; the frame is shifted out
  // right-first so the line sees start, data[0]..data[7], stop.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DATA_BITS-1:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buf_if
//   Host-side write interface of the buffered UART transmitter.
//   Signals:
//     wr_en   : push wr_data into the FIFO this cycle
//     wr_data : byte to transmit
//     full    : FIFO holds DEPTH entries
//     empty   : FIFO holds 0 entries
//     count   : current FIFO occupancy, $clog2(DEPTH)+1 bits
//   Modports:
//     master : host side (drives wr_en/wr_data)
//     slave  : transmitter side (drives full/empty/count)
// -----------------------------------------------------------------------------
interface uart_tx_buf_if #(
  parameter int unsigned DEPTH = 8
);
  import uart_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;

  modport master (
    output wr_en,
    output wr_data,
    input  full,
    input  empty,
    input  count
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output full,
    output empty,
    output count
  );

endinterface

// File: rtl/uart_tx_buf_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous FIFO feeding the UART transmitter.
//   Ports:
//     clk   : system clock (posedge)
//     rst_n : synchronous active-low reset; pointers and count clear,
//             stored contents are simply abandoned
//     push  : write din this cycle (ignored while full)
//     pop   : advance the read pointer this cycle (ignored while empty)
//     din   : write data
//     dout  : head entry, combinational read
//     full  : DEPTH entries held
//     empty : no entries held
//     count : occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  // full/empty come from the registered count only, so a push on a full
  // edge is dropped even if a pop frees a slot on that same edge.
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_do_push = push & ~w_full;
  assign w_do_pop  = pop & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are exactly PW bits wide, so +1 wraps modulo DEPTH.
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;

endmodule

// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
//   Buffered 8N1 UART transmitter. Bytes pushed through the host interface
//   are queued in a DEPTH-entry FIFO and sent back-to-back, LSB first.
//   Parameters:
//     BAUD_DIV : clocks per bit, 2..4095
//     DEPTH    : FIFO entries, power of 2, 2..16
//   Ports:
//     clk     : system clock (posedge)
//     rst_n   : synchronous active-low reset; aborts any frame in flight
//     host    : uart_tx_buf_if.slave (wr_en, wr_data, full, empty, count)
//     TX      : serial line, idle high
//     tx_busy : frame in progress, from the load edge to the end of stop bit
//     tx_done : one-cycle pulse in the first IDLE cycle after a stop bit
// -----------------------------------------------------------------------------
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned DEPTH    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_buf_if.slave  host,
  output logic          TX,
  output logic          tx_busy,
  output logic          tx_done
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [11:0] BAUD_TERM = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(FRAME_BITS - 1);

  tx_state_t             r_state;
  logic [FRAME_BITS-1:0] r_shreg;
  logic [11:0]           r_baud_cnt;
  logic [3:0]            r_bit_cnt;
  logic                  r_tx_busy;
  logic                  r_tx_done;

  logic                  w_pop;
  logic [DATA_BITS-1:0]  w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;

  // The FIFO is popped on the edge that leaves LOAD, the same edge that
  // captures its head into the shift register.
  assign w_pop = (r_state == LOAD);

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (host.wr_en),
    .pop   (w_pop),
    .din   (host.wr_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign host.full  = w_full;
  assign host.empty = w_empty;
  assign host.count = w_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shreg    <= '1;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state <= LOAD;
          end
        end

        LOAD: begin
          r_shreg    <= frame_of(w_head);
          r_baud_cnt <= '0;
          r_bit_cnt  <= '0;
          r_tx_busy  <= 1'b1;
          r_state    <= SHIFT;
        end

        SHIFT: begin
          if (r_baud_cnt == BAUD_TERM) begin
            r_baud_cnt <= '0;
            // Shift in ones so the line rests high once the stop bit is out.
            r_shreg    <= {1'b1, r_shreg[FRAME_BITS-1:1]};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
              r_state   <= IDLE;
              r_tx_busy <= 1'b0;
              r_tx_done <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign TX      = r_shreg[0];
  assign tx_busy = r_tx_busy;
  assign tx_done = r_tx_done;

endmodule
